// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl_pkg                                                  |
// | Shared state encoding and default geometry of the data memory.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_access_ctrl_pkg;

  localparam int c_addr_w = 16;
  localparam int c_data_w = 32;
  localparam int c_depth  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage : mem_access_ctrl_pkg
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl                                                      |
// | Single-outstanding load/store sequencer for the 32-bit data memory.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int DEPTH  = c_depth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic              mwr,
  output logic              mrd,
  output logic [ADDR_W-1:0] add,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] mdata
);

  // One extra bit so a DEPTH of 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] c_depth_ext = DEPTH[ADDR_W:0];

  state_t r_state;
  logic   w_out_of_range;

  assign w_out_of_range = ({1'b0, req_addr} >= c_depth_ext);
  assign req_ready      = (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      mwr       <= 1'b0;
      mrd       <= 1'b0;
      add       <= '0;
      data      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            rsp_we    <= req_we;
            rsp_rdata <= '0;
            if (w_out_of_range) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              add     <= req_addr;
              data    <= req_wdata;
              mwr     <= req_we;
              mrd     <= !req_we;
              rsp_err <= 1'b0;
              r_state <= ST_ISSUE;
            end
          end
        end

        // Memory samples the strobe at this edge; read data arrives one cycle later.
        ST_ISSUE: begin
          mwr <= 1'b0;
          mrd <= 1'b0;
          if (rsp_we) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          rsp_rdata <= mdata;
          rsp_valid <= 1'b1;
          r_state   <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_ctrl                                                   |
// | Directed bench for mem_access_ctrl with a registered-read memory.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_we;
  logic        rsp_err;
  logic        mwr;
  logic        mrd;
  logic [15:0] add;
  logic [31:0] data;
  logic [31:0] mdata;

  int checks   = 0;
  int failures = 0;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_we   (rsp_we),
    .rsp_err  (rsp_err),
    .mwr      (mwr),
    .mrd      (mrd),
    .add      (add),
    .data     (data),
    .mdata    (mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous write, registered read.
  logic [31:0] mem [16];
  initial for (int k = 0; k < 16; k++) mem[k] = 32'h0;
  initial mdata = 32'h0;
  always @(posedge clk) begin
    if (mwr) mem[add[3:0]] <= data;
    if (mrd) mdata <= mem[add[3:0]];
  end

  // Strobe monitor, sampled mid-cycle.
  int          mwr_cnt  = 0;
  int          mrd_cnt  = 0;
  int          both_cnt = 0;
  logic [15:0] last_wr_add  = 16'h0;
  logic [31:0] last_wr_data = 32'h0;
  always @(negedge clk) begin
    if (rst) begin
      if (mwr) begin
        mwr_cnt      <= mwr_cnt + 1;
        last_wr_add  <= add;
        last_wr_data <= data;
      end
      if (mrd) mrd_cnt <= mrd_cnt + 1;
      if (mwr && mrd) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge with the controller idle; rsp_ready assumed 1.
  task automatic txn(input logic we, input logic [15:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic e,
                     output logic rw, output int nwr, output int nrd,
                     output logic [15:0] wa, output logic [31:0] wdd);
    int wr0;
    int rd0;
    wr0 = mwr_cnt;
    rd0 = mrd_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~a;
    req_wdata = ~wd;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    e  = rsp_err;
    rw = rsp_we;
    @(posedge clk);
    #1;
    nwr = mwr_cnt - wr0;
    nrd = mrd_cnt - rd0;
    wa  = last_wr_add;
    wdd = last_wr_data;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          lat;
    int          nwr;
    int          nrd;
    int          seen;
    int          wr0;
    logic [31:0] rd;
    logic        e;
    logic        rw;
    logic [15:0] wa;
    logic [31:0] wdd;
    logic [31:0] v;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_mwr", {31'b0, mwr}, 32'h0);
    chk("rst_mrd", {31'b0, mrd}, 32'h0);
    chk("rst_add", {16'b0, add}, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_we_err", {30'b0, rsp_we, rsp_err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

    // Store 0xDEADBEEF to word 5.
    txn(1'b1, 16'd5, 32'hDEADBEEF, lat, rd, e, rw, nwr, nrd, wa, wdd);
    chk("st_lat", lat, 2);
    chk("st_rsp", {29'b0, rw, e, 1'b0}, 32'h4);
    chk("st_rdata", rd, 32'h0);
    chk("st_mwr_pulses", nwr, 1);
    chk("st_mrd_pulses", nrd, 0);
    chk("st_add", {16'b0, wa}, 32'd5);
    chk("st_data", wdd, 32'hDEADBEEF);

    // Load word 5 back.
    txn(1'b0, 16'd5, 32'h0, lat, rd, e, rw, nwr, nrd, wa, wdd);
    chk("ld_lat", lat, 3);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_we_err", {30'b0, rw, e}, 32'h0);
    chk("ld_mrd_pulses", nrd, 1);
    chk("ld_mwr_pulses", nwr, 0);

    // Out-of-range: just above depth, top of address space, and a store.
    txn(1'b0, 16'd16, 32'h0, lat, rd, e, rw, nwr, nrd, wa, wdd);
    chk("oor16_lat", lat, 1);
    chk("oor16_err", {31'b0, e}, 32'h1);
    chk("oor16_rdata", rd, 32'h0);
    chk("oor16_strobes", nwr + nrd, 0);
    txn(1'b0, 16'hFFFF, 32'h0, lat, rd, e, rw, nwr, nrd, wa, wdd);
    chk("oorffff_lat", lat, 1);
    chk("oorffff_err", {31'b0, e}, 32'h1);
    chk("oorffff_rdata", rd, 32'h0);
    chk("oorffff_strobes", nwr + nrd, 0);
    txn(1'b1, 16'd16, 32'h12345678, lat, rd, e, rw, nwr, nrd, wa, wdd);
    chk("oorst_we_err", {30'b0, rw, e}, 32'h3);
    chk("oorst_strobes", nwr + nrd, 0);

    // Backpressure: load held for 5 cycles while a store waits at the input.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'd5;
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_addr  = 16'd7;
    req_wdata = 32'h77;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("bp_lat", lat, 3);
    wr0 = mwr_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
    end
    chk("bp_no_accept", mwr_cnt - wr0, 0);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", {31'b0, rsp_valid}, 32'h0);
    chk("bp_released_ready", {31'b0, req_ready}, 32'h1);
    chk("bp_no_bypass", {31'b0, mwr}, 32'h0);
    @(negedge clk);
    chk("bp_next_mwr", {31'b0, mwr}, 32'h1);
    chk("bp_next_add", {16'b0, add}, 32'd7);
    chk("bp_next_data", data, 32'h77);
    #1 req_valid = 1'b0;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("bp_next_rsp", {30'b0, rsp_we, rsp_err}, 32'h2);
    @(posedge clk);
    #1;

    // Fill all words, then read them all back.
    for (int i = 0; i < 16; i++) begin
      v = 32'(i) * 32'h01010101;
      txn(1'b1, 16'(i), v, lat, rd, e, rw, nwr, nrd, wa, wdd);
    end
    for (int i = 0; i < 16; i++) begin
      v = 32'(i) * 32'h01010101;
      txn(1'b0, 16'(i), 32'h0, lat, rd, e, rw, nwr, nrd, wa, wdd);
      chk("fill_rdata", rd, v);
    end
    chk("never_both_strobes", both_cnt, 0);

    // Reset during ISSUE of a load.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'd3;
    @(posedge clk);
    #2;
    chk("mid_mrd_before", {31'b0, mrd}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_mrd", {31'b0, mrd}, 32'h0);
    chk("mid_add", {16'b0, add}, 32'h0);
    chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_req_ready", {31'b0, req_ready}, 32'h1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_no_response", seen, 0);
    @(posedge clk);
    #1;
    txn(1'b0, 16'd3, 32'h0, lat, rd, e, rw, nwr, nrd, wa, wdd);
    chk("mid_recover_rdata", rd, 32'h03030303);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_access_ctrl
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller for the 32-bit data memory: it drives the memory's mwr/mrd/add/data strobes and captures mdata.
- Accepts one load or store request at a time from the execute/writeback stage over a valid/ready handshake.
- Sequences the memory's single-cycle registered read latency and returns a response over a second valid/ready handshake.
- Rejects requests whose address falls outside the implemented memory depth, without touching the memory.

Parameters:
- ADDR_W, 16, request and memory address width.
- DATA_W, 32, data word width.
- DEPTH, 16, number of implemented memory words; any address >= DEPTH is out of range.

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_we  out  1  echo of req_we for the response.
- rsp_err  out  1  address out of range.
- mwr  out  1  memory write strobe.
- mrd  out  1  memory read strobe.
- add  out  ADDR_W  memory address.
- data  out  DATA_W  memory write data.
- mdata  in  DATA_W  memory read data; valid the cycle after the edge that sampled mrd=1.

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - mwr=0, mrd=0, add=0, data=0.
  - rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_err=0.
  - req_ready=1 one cycle after release.
- All outputs are registered except req_ready, which is (state==IDLE).
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, on req_valid&&req_ready:
  - Latch req_we into rsp_we.
  - If req_addr >= DEPTH: mwr=mrd=0, rsp_err=1, rsp_rdata=0, rsp_valid=1, go RESP.
  - Otherwise: add=req_addr, data=req_wdata, mwr=req_we, mrd=!req_we, rsp_err=0, go ISSUE.
- ISSUE: the memory samples the strobe at this edge. On this edge, clear mwr and mrd.
  - Store: rsp_valid=1, rsp_rdata=0, go RESP.
  - Load: go CAPTURE.
- CAPTURE: rsp_rdata<=mdata, rsp_valid<=1, go RESP.
- RESP: hold all rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0, go IDLE.
  - The next request is accepted no earlier than the following cycle. There is no response-to-request bypass.
- Latency from accept edge to rsp_valid high:
  - In range: load 3 cycles, store 2 cycles.
  - Out of range: 1 cycle.
- Throughput: one request in flight at a time.
- Strobe rules:
  - mwr and mrd are never high together.
  - Each strobe is high for exactly one cycle per accepted in-range request.
  - add and data are held from ISSUE until the next accept.
- Address comparison is unsigned over the full ADDR_W. Upper bits are never truncated, so address 16 with DEPTH=16 is an error and is not aliased to word 0.
- req_* inputs are ignored outside IDLE. Changes on them mid-operation must not affect add, data or the strobes.
- Reset asserted mid-operation:
  - Strobes drop immediately and the in-flight request is discarded with no response.
  - A store aborted in ISSUE may or may not have been written by the memory. This is the caller's responsibility.
- Reset is only ever applied asynchronously. No synchronous clear path exists.

Decomposition:
- Shared package holds:
  - The state encoding typedef (IDLE, ISSUE, CAPTURE, RESP, 2-bit).
  - Constants for the default ADDR_W, DATA_W and DEPTH, shared with the memory block.
- Single module; no sub-module is needed.
- The range check is a one-line comparator inside the module.

Test Plan:
- Store 0xDEADBEEF at address 5 with rsp_ready=1 -> mwr high exactly one cycle with add=5 and data=0xDEADBEEF; rsp_valid 2 cycles after accept with rsp_we=1, rsp_err=0, rsp_rdata=0.
- Load address 5 after that store -> mrd high one cycle; rsp_valid 3 cycles after accept with rsp_rdata=0xDEADBEEF; mwr never asserted.
- Load address 16, then address 0xFFFF -> no mrd/mwr pulse; rsp_valid 1 cycle after accept with rsp_err=1 and rsp_rdata=0.
- Load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable throughout; req_ready=0 throughout; a new req_valid is not accepted until the cycle after rsp_ready=1.
- Back-to-back stores to addresses 0..15 with values i*0x01010101, then loads of all 16 -> every load returns its value; mwr and mrd never high together.
- Assert rst low during ISSUE of a load -> mrd, rsp_valid and add go to 0 without a clock edge; no response follows; req_ready=1 in the first cycle after release.
